fft_r2_sequencer: RTL
=====================

// Module: fft_r2_sequencer
// PURPOSE
//  Sequences a single pipelined radix-2 butterfly (butterfly2 plus DSP48 multipliers) through an in-place
//  2**LOG2N-point DIT FFT held in a dual-port sample RAM.
//  Generates per-butterfly read pair addresses, twiddle ROM index, butterfly strobe and delayed
//  write-back addresses. Inserts a drain gap between stages so no read overtakes a pending write.
//  Sits between the top-level start/done handshake and the RAM/ROM/butterfly datapath.
// PARAMETERS
//  LOG2N   3  log2 of FFT size N; N/2 butterflies per stage, LOG2N stages
//  BF_LAT  2  cycles from rd_en (RAM read issue) to butterfly result valid at RAM write port, >=1
// PORTS
//  clk        in   1         clock
//  rst        in   1         asynchronous reset, active-high
//  start      in   1         request a transform; sampled only in IDLE
//  busy       out  1         high in every state except IDLE
//  done       out  1         one-cycle pulse, transform complete
//  stage      out  LOG2N     current stage index s (0..LOG2N-1)
//  rd_en      out  1         issue read of pair (rd_addr_a, rd_addr_b) and twiddle
//  rd_addr_a  out  LOG2N     upper butterfly input address
//  rd_addr_b  out  LOG2N     lower butterfly input address
//  tw_addr    out  LOG2N-1   twiddle ROM index, W_N^tw_addr
//  bf_start   out  1         butterfly start strobe, equal to rd_en
//  wr_en      out  1         write butterfly outputs to RAM
//  wr_addr_a  out  LOG2N     address for f2out0
//  wr_addr_b  out  LOG2N     address for f2out1
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; write-delay pipeline valid bits cleared; counters 0.
//   Applies mid-transform, taking effect immediately.
//  States:
//   IDLE --start--> RUN (or LOAD if FFT_BITREV_LOAD_EN).
//   RUN: one butterfly per cycle, k = 0..N/2-1; after k = N/2-1 go to DRAIN.
//   DRAIN: BF_LAT cycles, rd_en = 0. Then s++ and RUN, or DONE if s = LOG2N-1.
//   DONE: done = 1 for one cycle, then IDLE.
//  Address rules for stage s, half = 1<<s:
//   rd_addr_a = ((k>>s)<<(s+1)) | (k & (half-1))
//   rd_addr_b = rd_addr_a + half
//   tw_addr   = (k & (half-1)) << (LOG2N-1-s)
//  Write side: wr_en, wr_addr_a and wr_addr_b are rd_en, rd_addr_a and rd_addr_b delayed exactly BF_LAT cycles
//   through a shift register. The last write of a stage lands in the last DRAIN cycle.
//   The RAM must return newly written data on a read issued the following cycle.
//  Latency (without LOAD): start sampled at cycle 0; first rd_en at cycle 1;
//   done at cycle LOG2N*(N/2+BF_LAT)+1, which is 19 for the defaults.
//  Counters k and s wrap only under FSM control. tw_addr width LOG2N-1 covers N/2 twiddles.
//  start while busy: ignored, not queued. start held high: a new transform begins on the cycle after DONE returns to IDLE.
//  rd_en and wr_en may be high in the same cycle (pipelined stage body); the addresses differ by construction.
// CONFIGURATION
//  FFT_BITREV_LOAD_EN defined: adds ports in_valid(in,1), in_ready(out,1), ld_addr(out,LOG2N), ld_wr_en(out,1); all outputs 0 on reset.
//   Start enters LOAD: in_ready = 1. Sample n is accepted on in_valid & in_ready: ld_wr_en = 1 and ld_addr = bitrev(n), same cycle.
//   After sample N-1 is accepted: go to RUN, in_ready = 0. in_valid low stalls LOAD indefinitely.
//   done is then N + LOG2N*(N/2+BF_LAT)+1 cycles after start with in_valid held high.
//  Undefined: no LOAD state and no extra ports. The RAM must already hold bit-reversed input.
// TESTING
//  1 Defaults, start pulse at cycle 0: stage 0 pairs (0,1)(2,3)(4,5)(6,7), tw 0,0,0,0, rd_en high at cycles 1-4.
//  2 Same run: stage 1 pairs (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2; stage 2 pairs (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3.
//    Check rd_en low for 2 cycles between stages; done=1 exactly at cycle 19, busy=0 at cycle 20.
//  3 Every wr_en/wr_addr equals rd_en/rd_addr from 2 cycles earlier. With a behavioural RAM plus butterfly model,
//    impulse x[0]=1000 gives all 8 bins = 1000 (+/-1 LSB).
//  4 start pulsed at cycle 5 mid-run: no effect, done still at 19. start held high: second transform rd_en at cycle 21.
//  5 rst asserted at cycle 10: all outputs 0 that cycle and busy=0. No wr_en appears after reset release.
//    A fresh start yields the scenario 1 sequence.
//  6 FFT_BITREV_LOAD_EN: 8 samples n=0..7 produce ld_addr 0,4,2,6,1,5,3,7. A 3-cycle in_valid gap extends done by 3 cycles.

Source files
------------

// File: rtl/fft_r2_sequencer.sv
// Address/strobe sequencer for an in-place radix-2 DIT FFT around one pipelined butterfly.
// Optional macro FFT_BITREV_LOAD_EN adds a LOAD state that writes input samples in bit-reversed order.
module fft_r2_sequencer #(
    parameter int LOG2N  = 3,
    parameter int BF_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef FFT_BITREV_LOAD_EN
    input  logic             in_valid,
    output logic             in_ready,
    output logic [LOG2N-1:0] ld_addr,
    output logic             ld_wr_en,
`endif
    output logic             busy,
    output logic             done,
    output logic [LOG2N-1:0] stage,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic             bf_start,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b
);

    localparam int KW = LOG2N - 1;
    localparam int DW = $clog2(BF_LAT + 1);
    localparam logic [KW-1:0]    K_LAST = KW'((1 << KW) - 1);
    localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);
    localparam logic [DW-1:0]    D_LAST = DW'(BF_LAT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic             en;
        logic [LOG2N-1:0] a;
        logic [LOG2N-1:0] b;
    } acc_t;

    state_t           state_q;
    logic [KW-1:0]    k_q;
    logic [LOG2N-1:0] s_q;
    logic [DW-1:0]    drain_q;
    acc_t             rd_q;
    logic [KW-1:0]    tw_q;
    logic             busy_q;
    logic             done_q;
    acc_t             wr_pipe_q [BF_LAT];

    // Butterfly k of stage s reads the pair whose indices differ only in bit s.
    function automatic acc_t issue(input logic [KW-1:0] k, input logic [LOG2N-1:0] s);
        acc_t             r;
        logic [LOG2N-1:0] kk;
        logic [LOG2N-1:0] mask;
        kk   = LOG2N'(k);
        mask = (LOG2N'(1) << s) - LOG2N'(1);
        r.en = 1'b1;
        r.a  = ((kk >> s) << (s + LOG2N'(1))) | (kk & mask);
        r.b  = r.a | (LOG2N'(1) << s);
        return r;
    endfunction

    function automatic logic [KW-1:0] tw_of(input logic [KW-1:0] k, input logic [LOG2N-1:0] s);
        logic [KW-1:0] mask;
        mask = (KW'(1) << s) - KW'(1);
        return (k & mask) << (LOG2N'(LOG2N - 1) - s);
    endfunction

`ifdef FFT_BITREV_LOAD_EN
    localparam logic [LOG2N-1:0] N_LAST = LOG2N'((1 << LOG2N) - 1);

    logic             in_ready_q;
    logic [LOG2N-1:0] n_q;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    assign in_ready = in_ready_q;
    assign ld_wr_en = in_valid & in_ready_q;
    assign ld_addr  = bitrev(n_q);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            s_q     <= '0;
            drain_q <= '0;
            rd_q    <= '0;
            tw_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FFT_BITREV_LOAD_EN
            in_ready_q <= 1'b0;
            n_q        <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments let every register see the previous cycle's values,
            // so the later per-state assignments simply override these defaults.
            done_q <= 1'b0;
            rd_q   <= '0;
            tw_q   <= '0;
            case (state_q)
                IDLE: if (start) begin
                    busy_q <= 1'b1;
                    s_q    <= '0;
                    k_q    <= '0;
`ifdef FFT_BITREV_LOAD_EN
                    state_q    <= LOAD;
                    in_ready_q <= 1'b1;
                    n_q        <= '0;
`else
                    state_q <= RUN;
                    rd_q    <= issue('0, '0);
                    tw_q    <= tw_of('0, '0);
`endif
                end
`ifdef FFT_BITREV_LOAD_EN
                LOAD: if (in_valid) begin
                    if (n_q == N_LAST) begin
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        rd_q       <= issue('0, '0);
                        tw_q       <= tw_of('0, '0);
                    end else begin
                        n_q <= n_q + 1'b1;
                    end
                end
`endif
                RUN: begin
                    if (k_q == K_LAST) begin
                        state_q <= DRAIN;
                        drain_q <= '0;
                        k_q     <= '0;
                    end else begin
                        k_q  <= k_q + 1'b1;
                        rd_q <= issue(k_q + 1'b1, s_q);
                        tw_q <= tw_of(k_q + 1'b1, s_q);
                    end
                end
                // Hold off reads until the stage's last write has reached the RAM.
                DRAIN: begin
                    if (drain_q == D_LAST) begin
                        if (s_q == S_LAST) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            s_q     <= s_q + 1'b1;
                            rd_q    <= issue('0, s_q + 1'b1);
                            tw_q    <= tw_of('0, s_q + 1'b1);
                        end
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    s_q     <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the write-delay line is reset so a transform cut short by rst leaves no stray writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BF_LAT; i++) wr_pipe_q[i] <= '0;
        end else begin
            wr_pipe_q[0] <= rd_q;
            for (int i = 1; i < BF_LAT; i++) wr_pipe_q[i] <= wr_pipe_q[i-1];
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign stage     = s_q;
    assign rd_en     = rd_q.en;
    assign bf_start  = rd_q.en;
    assign rd_addr_a = rd_q.a;
    assign rd_addr_b = rd_q.b;
    assign tw_addr   = tw_q;
    assign wr_en     = wr_pipe_q[BF_LAT-1].en;
    assign wr_addr_a = wr_pipe_q[BF_LAT-1].a;
    assign wr_addr_b = wr_pipe_q[BF_LAT-1].b;

endmodule
